// File: rtl/change_dispenser_if.sv
// Request/amount handshake plus coin-hopper and status outputs of the change dispenser.
interface change_dispenser_if;
    logic       req;
    logic [9:0] amount;
    logic       ready;
    logic       coin_10;
    logic       coin_5;
    logic       coin_2;
    logic       coin_1;
    logic [9:0] remaining;
    logic [5:0] coin_count;
    logic       done;
    logic       err;

    modport master (
        output req, amount,
        input  ready, coin_10, coin_5, coin_2, coin_1, remaining, coin_count, done, err
    );

    modport slave (
        input  req, amount,
        output ready, coin_10, coin_5, coin_2, coin_1, remaining, coin_count, done, err
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy $10/$5/$2/$1 change dispenser: one paced pulse per coin on registered hopper lines,
// with remaining amount, coin count and done/err status.
module change_dispenser #(
    parameter int PULSE_CYCLES = 5000000,
    parameter int GAP_CYCLES   = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    state_t           state_reg, state_next;
    logic [9:0]       remaining_reg, remaining_next;
    logic [5:0]       coin_count_reg, coin_count_next;
    logic [3:0]       coin_reg, coin_next;    // bit 3 = $10 ... bit 0 = $1
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [9:0] denom [4];
    logic [3:0] fits;
    logic [3:0] sel;
    logic [9:0] sel_value;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_denom
            assign denom[gi] = (gi == 3) ? 10'd100 :
                               (gi == 2) ? 10'd50  :
                               (gi == 1) ? 10'd20  : 10'd10;
            assign fits[gi]  = (remaining_reg >= denom[gi]);
        end
    endgenerate

    // Highest fitting denomination wins; later (larger) indices override smaller ones.
    always_comb begin
        sel       = 4'b0000;
        sel_value = 10'd0;
        for (int i = 0; i < 4; i++) begin
            if (fits[i]) begin
                sel       = 4'b0001 << i;
                sel_value = denom[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            remaining_reg  <= 10'd0;
            coin_count_reg <= 6'd0;
            coin_reg       <= 4'b0000;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            coin_count_reg <= coin_count_next;
            coin_reg       <= coin_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        coin_count_next = coin_count_reg;
        coin_next       = coin_reg;
        err_next        = err_reg;
        cnt_next        = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    remaining_next  = bus.amount;
                    coin_count_next = 6'd0;
                    err_next        = 1'b0;
                    state_next      = SELECT;
                end
            end
            SELECT: begin
                if (|fits) begin
                    coin_next       = sel;
                    remaining_next  = remaining_reg - sel_value;
                    coin_count_next = coin_count_reg + 6'd1;
                    cnt_next        = CNT_W'(PULSE_CYCLES - 1);
                    state_next      = PULSE;
                end else begin
                    // Residual below $1 cannot be paid; flag it and finish.
                    err_next   = (remaining_reg != 10'd0);
                    state_next = DONE;
                end
            end
            PULSE: begin
                if (cnt_reg == '0) begin
                    coin_next  = 4'b0000;
                    cnt_next   = CNT_W'(GAP_CYCLES - 1);
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = SELECT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready      = (state_reg == IDLE);
    assign bus.done       = (state_reg == DONE);
    assign bus.err        = err_reg;
    assign bus.remaining  = remaining_reg;
    assign bus.coin_count = coin_count_reg;
    assign bus.coin_10    = coin_reg[3];
    assign bus.coin_5     = coin_reg[2];
    assign bus.coin_2     = coin_reg[1];
    assign bus.coin_1     = coin_reg[0];
endmodule
